// File: rtl/ram_seq.sv
// ram_seq: bus-side access sequencer for the RAM block.
//
// Accepts one read or write request at a time over a valid/ready handshake
// and generates the two-phase RAM protocol: an LDRAMD strobe with the address
// on bus_data, then an LDRAM strobe with we and the write data. Reads capture
// ram_q and return it with a one-cycle rsp_valid pulse; writes also pulse
// rsp_valid on completion.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_we/req_addr/req_wdata  request payload, latched on accept
//   rsp_valid/rsp_rdata  completion pulse, read data (held between reads)
//   bus_data, LDRAMD, LDRAM, we  RAM-side bus and strobes (all registered)
//   ram_q                RAM read data (combinational from the RAM)
//
// Optional feature: RAM_SEQ_ADDR_SKIP_EN skips the ADDR phase when the
// request address equals the address most recently loaded into the RAM.
module ram_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [WIDTH-1:0] bus_data,
  output logic             LDRAMD,
  output logic             LDRAM,
  output logic             we,
  input  logic [WIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACCESS,
    CAPT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             req_we_q, req_we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [WIDTH-1:0] bus_data_q, bus_data_d;
  logic             ldramd_q, ldramd_d;
  logic             ldram_q, ldram_d;
  logic             we_out_q, we_out_d;
  logic             accept;
  logic             skip_addr;

`ifdef RAM_SEQ_ADDR_SKIP_EN
  logic [WIDTH-1:0] last_addr_q, last_addr_d;
  logic             last_addr_valid_q, last_addr_valid_d;

  assign skip_addr = last_addr_valid_q && (req_addr == last_addr_q);
`else
  assign skip_addr = 1'b0;
`endif

  // req_ready_q is only set while idle, so it also gates acceptance for
  // the first cycle after reset release.
  assign accept = (state_q == IDLE) && req_valid && req_ready_q;

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef RAM_SEQ_ADDR_SKIP_EN
    last_addr_d       = last_addr_q;
    last_addr_valid_d = last_addr_valid_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          req_we_d = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          state_d  = skip_addr ? ACCESS : ADDR;
        end
      end
      ADDR: begin
        state_d = ACCESS;
`ifdef RAM_SEQ_ADDR_SKIP_EN
        last_addr_d       = addr_q;
        last_addr_valid_d = 1'b1;
`endif
      end
      ACCESS: state_d = req_we_q ? DONE : CAPT;
      CAPT: begin
        state_d     = DONE;
        rsp_rdata_d = ram_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state (and next latched payload) so
    // that every strobe comes straight out of a flop for the whole cycle.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
    ldramd_d    = (state_d == ADDR);
    ldram_d     = (state_d == ACCESS);
    we_out_d    = (state_d == ACCESS) && req_we_d;
    bus_data_d  = '0;
    if (state_d == ADDR) begin
      bus_data_d = addr_d;
    end else if ((state_d == ACCESS) && req_we_d) begin
      bus_data_d = wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      bus_data_q  <= '0;
      ldramd_q    <= 1'b0;
      ldram_q     <= 1'b0;
      we_out_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_data_q  <= bus_data_d;
      ldramd_q    <= ldramd_d;
      ldram_q     <= ldram_d;
      we_out_q    <= we_out_d;
    end
  end

`ifdef RAM_SEQ_ADDR_SKIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q       <= '0;
      last_addr_valid_q <= 1'b0;
    end else begin
      last_addr_q       <= last_addr_d;
      last_addr_valid_q <= last_addr_valid_d;
    end
  end
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_data  = bus_data_q;
  assign LDRAMD    = ldramd_q;
  assign LDRAM     = ldram_q;
  assign we        = we_out_q;

endmodule

// File: tb/tb_ram_seq.sv
// Testbench for ram_seq with a behavioural RAM and a transaction-level
// reference model (expected memory contents, last read data, expected
// latency and ADDR-skip decisions).
module tb_ram_seq;

  localparam int PERIOD = 10;
`ifdef RAM_SEQ_ADDR_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] bus_data;
  logic        LDRAMD;
  logic        LDRAM;
  logic        we;
  logic [15:0] ram_q;

  always #(PERIOD/2) clk = ~clk;

  ram_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bus_data  (bus_data),
    .LDRAMD    (LDRAMD),
    .LDRAM     (LDRAM),
    .we        (we),
    .ram_q     (ram_q)
  );

  // Behavioural RAM: address register loaded by LDRAMD, write on LDRAM&&we,
  // combinational read of the addressed word.
  logic [15:0] ram_mem [0:65535];
  logic [15:0] ram_addr = 16'h0000;
  always @(posedge clk) begin
    if (LDRAMD) ram_addr <= bus_data;
    if (LDRAM && we) ram_mem[ram_addr] <= bus_data;
  end
  assign ram_q = ram_mem[ram_addr];

  // Reference model state
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] written [$];
  logic [15:0] exp_rdata = 16'h0000;
  logic [15:0] last_addr = 16'h0000;
  bit          last_valid = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  time         acc_t = 0;
  time         prev_acc_t = 0;

  int checks = 0;
  int passed = 0;

  task automatic run_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input bit hold, input bit busy_toggle);
    int          n_lda, n_ld, lat, rdy_bad, both_bad, hold_bad;
    logic [15:0] bus_a, bus_w, exp_bus_w;
    logic        we_at;
    bit          skip;
    int          exp_lat;
    skip    = SKIP_EN && last_valid && (a == last_addr);
    exp_lat = (w ? 3 : 4) - (skip ? 1 : 0);
    n_lda = 0; n_ld = 0; lat = 0; rdy_bad = 0; both_bad = 0; hold_bad = 0;
    bus_a = '0; bus_w = '0; we_at = 1'b0;

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL idle_before_req: ready=%b rsp_valid=%b expected 1/0", req_ready, rsp_valid);
    else passed++;
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    prev_acc_t = acc_t;
    acc_t = $time;

    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (busy_toggle) begin
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        req_we    = 1'($urandom);
      end else if (!hold) begin
        req_valid = 1'b0;
      end
      if (LDRAMD) begin n_lda++; bus_a = bus_data; end
      if (LDRAM) begin n_ld++; bus_w = bus_data; we_at = we; end
      if (LDRAMD && LDRAM) both_bad++;
      if (req_ready) rdy_bad++;
      if (w && rsp_rdata !== exp_rdata) hold_bad++;
      if (rsp_valid) begin
        lat = c;
        if (!hold) req_valid = 1'b0;
      end
    end

    // model update
    if (w) begin
      ref_mem[a] = d;
      written.push_back(a);
    end else begin
      exp_rdata = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    end
    if (!skip) begin last_addr = a; last_valid = 1'b1; end
    prev_addr = a;
    exp_bus_w = w ? d : 16'h0000;

    checks++;
    if (lat != exp_lat) $display("FAIL latency a=%h we=%b: got %0d expected %0d", a, w, lat, exp_lat);
    else passed++;
    checks++;
    if (n_lda != (skip ? 0 : 1)) $display("FAIL ldramd_count a=%h: got %0d expected %0d", a, n_lda, skip ? 0 : 1);
    else passed++;
    if (!skip) begin
      checks++;
      if (bus_a !== a) $display("FAIL addr_bus: got %h expected %h", bus_a, a);
      else passed++;
    end
    checks++;
    if (n_ld != 1) $display("FAIL ldram_count a=%h: got %0d expected 1", a, n_ld);
    else passed++;
    checks++;
    if (we_at !== w) $display("FAIL we_at_ldram a=%h: got %b expected %b", a, we_at, w);
    else passed++;
    checks++;
    if (bus_w !== exp_bus_w) $display("FAIL data_bus a=%h: got %h expected %h", a, bus_w, exp_bus_w);
    else passed++;
    checks++;
    if (both_bad != 0 || rdy_bad != 0)
      $display("FAIL strobe_overlap_or_ready: overlap=%0d ready_busy=%0d expected 0/0", both_bad, rdy_bad);
    else passed++;
    checks++;
    if (rsp_rdata !== exp_rdata) $display("FAIL rsp_rdata a=%h: got %h expected %h", a, rsp_rdata, exp_rdata);
    else passed++;
    if (w) begin
      checks++;
      if (hold_bad != 0) $display("FAIL rdata_hold_on_write: changed in %0d cycles expected 0", hold_bad);
      else passed++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    #3;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, bus_data, LDRAMD, LDRAM, we} !== '0)
      $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h bus=%h lda=%b ld=%b we=%b expected all 0",
               req_ready, rsp_valid, rsp_rdata, bus_data, LDRAMD, LDRAM, we);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) $display("FAIL ready_before_edge: got %b expected 0", req_ready);
    else passed++;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL ready_after_edge: got %b expected 1", req_ready);
    else passed++;
  endtask

  task automatic test_write;
    run_req(1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0);
  endtask

  task automatic test_readback;
    run_req(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
    run_req(1'b1, 16'h0030, 16'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_req(1'b1, 16'h0000, 16'h1234, 1'b1, 1'b0);
    run_req(1'b1, 16'hFFFF, 16'hA5C3, 1'b0, 1'b0);
    checks++;
    if (acc_t - prev_acc_t != 4 * PERIOD)
      $display("FAIL accept_spacing: got %0t expected %0d", acc_t - prev_acc_t, 4 * PERIOD);
    else passed++;
    run_req(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_req(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_busy;
    run_req(1'b1, 16'h0055, 16'h6A6A, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (LDRAMD !== 1'b0 || LDRAM !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL busy_no_extra_accept: lda=%b ld=%b rdy=%b expected 0/0/1", LDRAMD, LDRAM, req_ready);
    else passed++;
    run_req(1'b0, 16'h0055, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_addr_skip;
    run_req(1'b1, 16'h0020, 16'hC0DE, 1'b0, 1'b0);
    run_req(1'b1, 16'h0021, 16'h7777, 1'b0, 1'b0);
    run_req(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);
    run_req(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);
    run_req(1'b0, 16'h0021, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0021; req_wdata = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (LDRAMD !== 1'b1) $display("FAIL mid_addr_phase: LDRAMD got %b expected 1", LDRAMD);
    else passed++;
    rst_n = 1'b0;
    #1;
    exp_rdata = 16'h0000;
    last_valid = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, bus_data, LDRAMD, LDRAM, we} !== '0)
      $display("FAIL mid_reset_outputs: got rdy=%b rv=%b rd=%h bus=%h lda=%b ld=%b we=%b expected all 0",
               req_ready, rsp_valid, rsp_rdata, bus_data, LDRAMD, LDRAM, we);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL ready_after_mid_reset: got %b expected 1", req_ready);
    else passed++;
    // Same address as the last completed access: ADDR must still run.
    run_req(1'b0, 16'h0021, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic        w;
    logic [15:0] a;
    for (int i = 0; i < 30; i++) begin
      w = (written.size() == 0) || ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) a = prev_addr;
      else if (w) a = 16'($urandom);
      else a = written[$urandom_range(0, written.size() - 1)];
      run_req(w, a, 16'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_back_to_back();
    test_busy();
    test_addr_skip();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
